// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, direction encoding and output-register occupancy states.
package router_pkg;

    localparam int FLIT_W = 15;
    localparam int NPORTS = 5;

    typedef enum logic [2:0] {
        DIR_E  = 3'd0,
        DIR_W  = 3'd1,
        DIR_N  = 3'd2,
        DIR_S  = 3'd3,
        DIR_PE = 3'd4
    } dir_e;

    // Flit field start bits, counted from the left in [0:FLIT_W-1] order.
    localparam int DST_LO = 0;
    localparam int HOP_LO = 2;
    localparam int SRC_LO = 5;
    localparam int PAY_LO = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } occ_e;

    function automatic logic [2:0] ptr_after(input logic [2:0] idx);
        if (idx >= 3'(DIR_PE)) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
// It grants the first set request found scanning i_ptr, i_ptr+1, ... modulo N.
module rr_pick
    import router_pkg::*;
#(
    parameter int N = router_pkg::NPORTS
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [2:0]   o_gnt_idx,
    output logic         o_any
);

    logic [3:0] w_pos;

    // Scan from the pointer with wrap and keep the first hit.
    always_comb begin
        o_gnt     = {N{1'b0}};
        o_gnt_idx = 3'd0;
        o_any     = 1'b0;
        w_pos     = 4'd0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + 4'(k);
            if (w_pos >= 4'(N)) begin
                w_pos = w_pos - 4'(N);
            end else begin
                w_pos = w_pos;
            end
            if (!o_any && i_req[w_pos[2:0]]) begin
                o_any            = 1'b1;
                o_gnt[w_pos[2:0]] = 1'b1;
                o_gnt_idx        = w_pos[2:0];
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter for one router output port.
// It grants one of five requesters and holds the granted flit in a single output register.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int WIDTH  = router_pkg::FLIT_W,
    parameter int NPORTS = router_pkg::NPORTS,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req_valid,
    input  logic [NPORTS*WIDTH-1:0]   req_data,
    output logic [NPORTS-1:0]         req_ready,
    output logic                      out_valid,
    output logic [0:WIDTH-1]          out_data,
    output logic [2:0]                out_src,
    input  logic                      out_ready,
    output logic [NPORTS*CNT_W-1:0]   grant_cnt
);

    occ_e               r_state;
    occ_e               w_state_nxt;
    logic [0:WIDTH-1]   r_data;
    logic [2:0]         r_src;
    logic [2:0]         r_ptr;
    logic [CNT_W-1:0]   r_cnt [NPORTS];

    logic               w_load_en;
    logic [NPORTS-1:0]  w_req;
    logic [NPORTS-1:0]  w_gnt;
    logic [2:0]         w_idx;
    logic               w_any;
    logic [0:WIDTH-1]   w_flit;

    // The picker only sees requests when the register is free or draining, and never during reset.
    always_comb begin
        w_load_en = (r_state == ST_EMPTY) || out_ready;
        if (w_load_en && !rst) begin
            w_req = req_valid;
        end else begin
            w_req = {NPORTS{1'b0}};
        end
        w_flit = req_data[w_idx*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N (NPORTS)
    ) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx),
        .o_any     (w_any)
    );

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant always fills the register; it only empties when drained without a grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_any) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_any) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Flit capture and pointer advance happen only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
            r_src  <= 3'd0;
            r_ptr  <= 3'd0;
        end else if (w_any) begin
            r_data <= w_flit;
            r_src  <= w_idx;
            r_ptr  <= ptr_after(w_idx);
        end else begin
            r_data <= r_data;
            r_src  <= r_src;
            r_ptr  <= r_ptr;
        end
    end

    // Per-requester saturating grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_any && (w_idx == 3'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Output packing.
    always_comb begin
        grant_cnt = {(NPORTS*CNT_W){1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
        req_ready = w_gnt;
        out_valid = (r_state == ST_FULL);
        out_data  = r_data;
        out_src   = r_src;
    end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with a flit scoreboard.
// A second instance with 2-bit counters covers counter saturation.
module tb_router_out_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid;
    logic [74:0] req_data;
    logic        out_ready;

    logic [4:0]  rr_a, rr_b;
    logic        ov_a, ov_b;
    logic [0:14] od_a, od_b;
    logic [2:0]  os_a, os_b;
    logic [39:0] gc_a;
    logic [9:0]  gc_b;

    int errors = 0;
    int checks = 0;
    logic [14:0] sb_q [$];
    logic [14:0] cur [5];

    always #5 clk = ~clk;

    router_out_arbiter #(.WIDTH(15), .NPORTS(5), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr_a), .out_valid(ov_a), .out_data(od_a), .out_src(os_a),
        .out_ready(out_ready), .grant_cnt(gc_a)
    );

    router_out_arbiter #(.WIDTH(15), .NPORTS(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr_b), .out_valid(ov_b), .out_data(od_b), .out_src(os_b),
        .out_ready(out_ready), .grant_cnt(gc_b)
    );

    // Every granted flit must leave exactly once, unmodified and in grant order.
    always @(posedge clk) begin
        logic [14:0] exp_f;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (ov_a && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got %h, required no flit", od_a);
                end else begin
                    exp_f = sb_q.pop_front();
                    if (od_a !== exp_f) begin
                        errors++;
                        $display("FAIL sb_data: got %h, required %h", od_a, exp_f);
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (rr_a[i]) sb_q.push_back(req_data[i*15 +: 15]);
            end
        end
    end

    function automatic logic [14:0] mk(input int src, input int seq);
        return 15'(src * 256 + seq + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int i, input logic [14:0] f);
        req_data[i*15 +: 15] = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 5'b00000;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 5'b00000; req_data = 75'd0; out_ready = 1'b0;
        #1;
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", ov_a); end
        req_valid = 5'b11111;
        #1;
        checks++; if (rr_a !== 5'b00000) begin errors++; $display("FAIL rst_ready: got %b, required 00000", rr_a); end
        req_valid = 5'b00000;
        tick(); tick();
        rst = 1'b0;
        set_flit(2, mk(2, 0));
        req_valid = 5'b00100;
        tick();
        req_valid = 5'b00000;
        tick();
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b, required 1", ov_a); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b, required 0", ov_a); end
        checks++; if (gc_a !== 40'd0) begin errors++; $display("FAIL async_rst_cnt: got %h, required 0", gc_a); end
        tick();
        rst = 1'b0;
        req_valid = 5'b11111;
        out_ready = 1'b1;
        #1;
        checks++; if (rr_a !== 5'b00001) begin errors++; $display("FAIL rst_ptr: got %b, required 00001", rr_a); end
        req_valid = 5'b00000;
        tick();
    endtask

    task automatic test_single();
        logic [14:0] f;
        f = 15'b010000010000000;
        set_flit(2, f);
        req_valid = 5'b00100;
        out_ready = 1'b1;
        #1;
        checks++; if (rr_a !== 5'b00100) begin errors++; $display("FAIL single_ready: got %b, required 00100", rr_a); end
        tick();
        req_valid = 5'b00000;
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", ov_a); end
        checks++; if (od_a !== f) begin errors++; $display("FAIL single_data: got %b, required %b", od_a, f); end
        checks++; if (os_a !== 3'd2) begin errors++; $display("FAIL single_src: got %0d, required 2", os_a); end
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL single_drain: got %b, required 0", ov_a); end
        checks++; if (od_a !== f) begin errors++; $display("FAIL single_keep: got %b, required %b", od_a, f); end
    endtask

    task automatic test_all_rr();
        int e;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cur[i] = mk(i, 0);
            set_flit(i, cur[i]);
        end
        req_valid = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            e = k % 5;
            #1;
            checks++; if (rr_a !== 5'(1 << e)) begin errors++; $display("FAIL rr_ready[%0d]: got %b, required %b", k, rr_a, 5'(1 << e)); end
            tick();
            checks++; if (os_a !== 3'(e)) begin errors++; $display("FAIL rr_src[%0d]: got %0d, required %0d", k, os_a, e); end
            checks++; if (od_a !== cur[e]) begin errors++; $display("FAIL rr_data[%0d]: got %h, required %h", k, od_a, cur[e]); end
            if (k == 4) begin
                checks++; if (gc_a !== {5{8'd1}}) begin errors++; $display("FAIL rr_cnt: got %h, required %h", gc_a, {5{8'd1}}); end
            end
            cur[e] = mk(e, k + 1);
            set_flit(e, cur[e]);
        end
        req_valid = 5'b00000;
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b, required 0", ov_a); end
    endtask

    task automatic test_backpressure();
        logic [14:0] held;
        req_valid = 5'b01010;
        out_ready = 1'b0;
        #1;
        checks++; if (rr_a !== 5'b00010) begin errors++; $display("FAIL bp_first: got %b, required 00010", rr_a); end
        tick();
        held = cur[1];
        cur[1] = mk(1, 10);
        set_flit(1, cur[1]);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rr_a !== 5'b00000) begin errors++; $display("FAIL bp_ready[%0d]: got %b, required 00000", c, rr_a); end
            checks++; if (od_a !== held || os_a !== 3'd1 || ov_a !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b, required %h/1/1", c, od_a, os_a, ov_a, held); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (rr_a !== 5'b01000) begin errors++; $display("FAIL bp_next: got %b, required 01000", rr_a); end
        tick();
        checks++; if (os_a !== 3'd3 || od_a !== cur[3]) begin errors++; $display("FAIL bp_s: got %0d/%h, required 3/%h", os_a, od_a, cur[3]); end
        req_valid = 5'b00010;
        #1;
        checks++; if (rr_a !== 5'b00010) begin errors++; $display("FAIL bp_w_ready: got %b, required 00010", rr_a); end
        tick();
        checks++; if (os_a !== 3'd1 || od_a !== cur[1]) begin errors++; $display("FAIL bp_w: got %0d/%h, required 1/%h", os_a, od_a, cur[1]); end
        req_valid = 5'b00000;
        tick();
    endtask

    task automatic test_back_to_back();
        set_flit(3, mk(3, 20));
        req_valid = 5'b01000;
        out_ready = 1'b1;
        tick();
        set_flit(0, mk(0, 20));
        set_flit(4, mk(4, 20));
        req_valid = 5'b10001;
        #1;
        checks++; if (rr_a !== 5'b10000) begin errors++; $display("FAIL b2b_pe_ready: got %b, required 10000", rr_a); end
        tick();
        checks++; if (ov_a !== 1'b1 || os_a !== 3'd4 || od_a !== mk(4, 20)) begin errors++; $display("FAIL b2b_pe: got %b/%0d/%h, required 1/4/%h", ov_a, os_a, od_a, mk(4, 20)); end
        req_valid = 5'b00001;
        #1;
        checks++; if (rr_a !== 5'b00001) begin errors++; $display("FAIL b2b_e_ready: got %b, required 00001", rr_a); end
        tick();
        checks++; if (ov_a !== 1'b1 || os_a !== 3'd0 || od_a !== mk(0, 20)) begin errors++; $display("FAIL b2b_e: got %b/%0d/%h, required 1/0/%h", ov_a, os_a, od_a, mk(0, 20)); end
        req_valid = 5'b00000;
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b, required 0", ov_a); end
    endtask

    task automatic test_saturation_idle();
        do_reset();
        out_ready = 1'b1;
        req_valid = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            set_flit(0, mk(0, 30 + k));
            tick();
        end
        req_valid = 5'b00000;
        tick();
        checks++; if (gc_b !== 10'b0000000011) begin errors++; $display("FAIL sat_cnt_b: got %b, required 0000000011", gc_b); end
        checks++; if (gc_a !== 40'd5) begin errors++; $display("FAIL cnt_a: got %h, required 5", gc_a); end
        checks++; if (ov_b !== 1'b0 || os_b !== 3'd0 || od_b !== mk(0, 34)) begin errors++; $display("FAIL sat_out_b: got %b/%0d/%h, required 0/0/%h", ov_b, os_b, od_b, mk(0, 34)); end
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) set_flit(i, mk(i, 40));
        req_valid = 5'b11111;
        #1;
        checks++; if (rr_a !== 5'b00010 || rr_b !== 5'b00010) begin errors++; $display("FAIL idle_ptr: got %b/%b, required 00010", rr_a, rr_b); end
        tick();
        req_valid = 5'b00000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_backpressure();
        test_back_to_back();
        test_saturation_idle();
        tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_left: got %0d flits, required 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
